// File: rtl/pma_rx_pkg.sv
// Shared types and constants for the RX PMA deserialiser / comma aligner.
// Optional feature macro used by the top: PMA_RX_BIT_SLIP_EN.
package pma_rx_pkg;

  // K28.5 comma, bit0 = first received bit ("a"), both running disparities.
  localparam logic [9:0] K28P5_RDN = 10'h17C;
  localparam logic [9:0] K28P5_RDP = 10'h283;

  // Width of the good/miss comma counters (covers thresholds 1..15).
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } rx_state_e;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + CNT_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/pma_comma_det.sv
// Combinational K28.5 comma detector over a W-bit window.
// Comma detection exists only for 10-bit words; other widths never match.
module pma_comma_det
  import pma_rx_pkg::*;
#(
  parameter int W = 10
) (
  input  logic [W-1:0] window,
  output logic         match
);

  generate
    if (W == 10) begin : g_cmp
      // Compare the window against both disparities of K28.5.
      always_comb begin
        match = (window == K28P5_RDN) || (window == K28P5_RDP);
      end
    end else begin : g_bypass
      assign match = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/pma_rx_deser_align.sv
// RX PMA path: polarity inversion, serial-to-parallel shifting and
// K28.5 word alignment with a HUNT/CHECK/LOCKED state machine.
// Optional feature macro: PMA_RX_BIT_SLIP_EN (adds the Bit_Slip input).
module pma_rx_deser_align
  import pma_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int LOCK_COUNT = 3,
  parameter int LOSS_COUNT = 4
) (
  input  logic                  Bit_Rate_Clk,
  input  logic                  Rst_n,
  input  logic                  Ser_in,
  input  logic                  RxPolarity,
`ifdef PMA_RX_BIT_SLIP_EN
  input  logic                  Bit_Slip,
`endif
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  Data_valid,
  output logic                  K285,
  output logic                  Locked
);

  localparam int              PH_W    = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [PH_W-1:0] LAST_PH = PH_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] LOCK_N = CNT_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] LOSS_N = CNT_W'(LOSS_COUNT);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  // Only the W-1 newest bits are kept: the full window is {new bit, hist_q},
  // and the oldest bit would fall off on the next shift anyway.
  logic [DATA_WIDTH-2:0] hist_q, hist_d;
  logic [DATA_WIDTH-1:0] sr_d;
  logic [PH_W-1:0]       phase_q, phase_d;
  rx_state_e             state_q, state_d;
  logic [CNT_W-1:0]      good_q, good_d;
  logic [CNT_W-1:0]      miss_q, miss_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  k285_q, k285_d;
  logic                  locked_q, locked_d;

  logic bit_s;
  logic match_s;
  logic boundary_s;
  logic realign_s;
  logic slip_s;
  logic emit_s;

`ifdef PMA_RX_BIT_SLIP_EN
  logic slip_q, slip_d;
`endif

  // Comma compare on the post-shift window (includes this cycle's bit).
  pma_comma_det #(.W(DATA_WIDTH)) u_comma_det (
    .window (sr_d),
    .match  (match_s)
  );

  // Next-state logic: shift, alignment FSM, phase counter and word emission.
  always_comb begin
    bit_s      = Ser_in ^ RxPolarity;
    sr_d       = {bit_s, hist_q};
    hist_d     = sr_d[DATA_WIDTH-1:1];
    boundary_s = (phase_q == LAST_PH);

    state_d    = state_q;
    good_d     = good_q;
    miss_d     = miss_q;
    realign_s  = 1'b0;

    case (state_q)
      HUNT: begin
        if (match_s) begin
          realign_s = 1'b1;
          good_d    = ONE_C;
          miss_d    = '0;
          state_d   = (LOCK_N == ONE_C) ? LOCKED : CHECK;
        end else begin
          good_d = '0;
          miss_d = '0;
        end
      end
      CHECK: begin
        if (match_s && boundary_s) begin
          good_d = sat_inc(good_q);
          if (sat_inc(good_q) >= LOCK_N) begin
            state_d = LOCKED;
            miss_d  = '0;
          end else begin
            state_d = CHECK;
          end
        end else if (match_s) begin
          // Comma found at a new position: move the boundary here.
          realign_s = 1'b1;
          good_d    = ONE_C;
        end else begin
          good_d = good_q;
        end
      end
      LOCKED: begin
        if (match_s && boundary_s) begin
          miss_d = '0;
        end else if (match_s) begin
          // Off-boundary comma while locked: count it, never move the boundary.
          if (sat_inc(miss_q) >= LOSS_N) begin
            state_d = HUNT;
            good_d  = '0;
            miss_d  = '0;
          end else begin
            miss_d = sat_inc(miss_q);
          end
        end else begin
          miss_d = miss_q;
        end
      end
      default: begin
        state_d = HUNT;
        good_d  = '0;
        miss_d  = '0;
      end
    endcase

`ifdef PMA_RX_BIT_SLIP_EN
    slip_d = Bit_Slip;
    slip_s = Bit_Slip & ~slip_q & (state_q != LOCKED);
`else
    slip_s = 1'b0;
`endif

    // Realign wins over a slip and over the free-running boundary; a slip
    // holds the phase one cycle so the boundary is pushed one bit later.
    if (realign_s) begin
      emit_s  = 1'b1;
      phase_d = '0;
    end else if (slip_s) begin
      emit_s  = 1'b0;
      phase_d = phase_q;
    end else if (boundary_s) begin
      emit_s  = 1'b1;
      phase_d = '0;
    end else begin
      emit_s  = 1'b0;
      phase_d = phase_q + PH_W'(1);
    end

    if (emit_s) begin
      data_out_d = sr_d;
    end else begin
      data_out_d = data_out_q;
    end
    data_valid_d = emit_s;
    k285_d       = emit_s & match_s;
    locked_d     = (state_d == LOCKED);
  end

  // State and output registers; async reset discards any partial word.
  always_ff @(posedge Bit_Rate_Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      hist_q       <= '0;
      phase_q      <= '0;
      state_q      <= HUNT;
      good_q       <= '0;
      miss_q       <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      k285_q       <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      hist_q       <= hist_d;
      phase_q      <= phase_d;
      state_q      <= state_d;
      good_q       <= good_d;
      miss_q       <= miss_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      k285_q       <= k285_d;
      locked_q     <= locked_d;
    end
  end

`ifdef PMA_RX_BIT_SLIP_EN
  // Previous Bit_Slip level for rising-edge detection.
  always_ff @(posedge Bit_Rate_Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      slip_q <= 1'b0;
    end else begin
      slip_q <= slip_d;
    end
  end
`endif

  assign Data_out   = data_out_q;
  assign Data_valid = data_valid_q;
  assign K285       = k285_q;
  assign Locked     = locked_q;

endmodule

// File: tb/tb_pma_rx_deser_align.sv
// Directed self-checking bench for pma_rx_deser_align (default build).
module tb_pma_rx_deser_align;

  logic       clk;
  logic       rst_n;
  logic       ser_in;
  logic       rx_pol;
  logic [9:0] data_out;
  logic       data_valid;
  logic       k285;
  logic       locked;
`ifdef PMA_RX_BIT_SLIP_EN
  logic       bit_slip;
`endif

  int   total;
  int   bad;
  int   dv_cnt;
  int   k_cnt;
  logic stream_inv;

  localparam logic [9:0] COMMA   = 10'h17C;
  localparam logic [9:0] COMMA_P = 10'h283;
  localparam logic [6:0] PREAMB  = 7'b0110100;

  pma_rx_deser_align #(
    .DATA_WIDTH (10),
    .LOCK_COUNT (3),
    .LOSS_COUNT (4)
  ) dut (
    .Bit_Rate_Clk (clk),
    .Rst_n        (rst_n),
    .Ser_in       (ser_in),
    .RxPolarity   (rx_pol),
`ifdef PMA_RX_BIT_SLIP_EN
    .Bit_Slip     (bit_slip),
`endif
    .Data_out     (data_out),
    .Data_valid   (data_valid),
    .K285         (k285),
    .Locked       (locked)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk10(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one line bit (optionally inverted on the wire), sample 1 after the edge.
  task automatic send_bit(input logic b);
    ser_in = b ^ stream_inv;
    @(posedge clk);
    #1;
    if (data_valid) dv_cnt++;
    if (data_valid && k285) k_cnt++;
  endtask

  task automatic send_word(input logic [9:0] w);
    for (int i = 0; i < 10; i++) send_bit(w[i]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) send_bit(1'($urandom));
    rst_n  = 1'b1;
    dv_cnt = 0;
    k_cnt  = 0;
  endtask

  // Preamble + 3 aligned commas; the emitted word is exp_w (RD- or RD+).
  task automatic lock_seq(input logic [9:0] exp_w);
    for (int i = 0; i < 7; i++) send_bit(PREAMB[i]);
    for (int i = 0; i < 9; i++) send_bit(COMMA[i]);
    chk_int("pre_k285_cnt", k_cnt, 0);
    chk_int("pre_dv_cnt", dv_cnt, 1);
    send_bit(COMMA[9]);
    chk1("c1_dv", data_valid, 1'b1);
    chk10("c1_data", data_out, exp_w);
    chk1("c1_k", k285, 1'b1);
    chk1("c1_lock", locked, 1'b0);
    send_word(COMMA);
    chk1("c2_dv", data_valid, 1'b1);
    chk10("c2_data", data_out, exp_w);
    chk1("c2_lock", locked, 1'b0);
    send_word(COMMA);
    chk1("c3_dv", data_valid, 1'b1);
    chk10("c3_data", data_out, exp_w);
    chk1("c3_k", k285, 1'b1);
    send_bit(1'b0);
    chk1("lock_after", locked, 1'b1);
    chk1("lock_after_dv", data_valid, 1'b0);
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    dv_cnt     = 0;
    k_cnt      = 0;
    clk        = 1'b0;
    rst_n      = 1'b0;
    ser_in     = 1'b0;
    rx_pol     = 1'b0;
    stream_inv = 1'b0;
`ifdef PMA_RX_BIT_SLIP_EN
    bit_slip   = 1'b0;
`endif

    // Reset held while random bits stream in.
    repeat (5) send_bit(1'($urandom));
    chk10("rst_data", data_out, 10'h000);
    chk1("rst_dv", data_valid, 1'b0);
    chk1("rst_k", k285, 1'b0);
    chk1("rst_lock", locked, 1'b0);
    rst_n  = 1'b1;
    dv_cnt = 0;
    k_cnt  = 0;

    // Plain lock on RD- commas.
    lock_seq(COMMA);

    // Inverted line, RxPolarity=1: identical result.
    stream_inv = 1'b1;
    rx_pol     = 1'b1;
    do_reset();
    lock_seq(COMMA);

    // Inverted line, RxPolarity=0: RD+ commas seen.
    rx_pol = 1'b0;
    do_reset();
    lock_seq(COMMA_P);
    stream_inv = 1'b0;

    // Loss of lock: four commas one bit off the boundary.
    do_reset();
    lock_seq(COMMA);
    repeat (3) send_word(COMMA);
    chk1("loss_3_lock", locked, 1'b1);
    send_word(COMMA);
    chk1("loss_4_lock", locked, 0);

    // Three misses then an aligned comma clears the miss count.
    do_reset();
    lock_seq(COMMA);
    repeat (3) send_word(COMMA);
    chk1("hold_3_lock", locked, 1'b1);
    repeat (9) send_bit(1'b0);
    send_word(COMMA);
    chk1("hold_al_dv", data_valid, 1'b1);
    chk10("hold_al_data", data_out, COMMA);
    chk1("hold_al_lock", locked, 1'b1);
    send_bit(1'b0);
    repeat (3) send_word(COMMA);
    chk1("hold_again_lock", locked, 1'b1);

    // Realign in CHECK: second comma 3 bits off the first boundary.
    do_reset();
    for (int i = 0; i < 7; i++) send_bit(PREAMB[i]);
    send_word(COMMA);
    chk1("ra_c1_dv", data_valid, 1'b1);
    chk1("ra_c1_lock", locked, 1'b0);
    repeat (3) send_bit(1'b0);
    send_word(COMMA);
    chk1("ra_c2_dv", data_valid, 1'b1);
    chk10("ra_c2_data", data_out, COMMA);
    chk1("ra_c2_k", k285, 1'b1);
    send_word(COMMA);
    chk1("ra_c3_lock", locked, 1'b0);
    send_word(COMMA);
    chk1("ra_c4_dv", data_valid, 1'b1);
    chk10("ra_c4_data", data_out, COMMA);
    send_bit(1'b0);
    chk1("ra_lock", locked, 1'b1);

    // Async reset while locked, then fresh re-lock.
    do_reset();
    lock_seq(COMMA);
    repeat (9) send_bit(1'b0);
    send_word(10'h155);
    chk1("d_dv", data_valid, 1'b1);
    chk10("d_data", data_out, 10'h155);
    chk1("d_k", k285, 1'b0);
    chk1("d_lock", locked, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("ar_lock", locked, 1'b0);
    chk1("ar_dv", data_valid, 1'b0);
    chk10("ar_data", data_out, 10'h000);
    #1 rst_n = 1'b1;
    send_word(COMMA);
    send_word(COMMA);
    chk1("rl_c2_lock", locked, 1'b0);
    send_word(COMMA);
    chk1("rl_c3_dv", data_valid, 1'b1);
    chk10("rl_c3_data", data_out, COMMA);
    send_bit(1'b0);
    chk1("rl_lock", locked, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
